// File: rtl/ibex_fp_pkg.sv
// ----------------------------------------------------------------------------
// ibex_fp_pkg
// Shared types and constants for the floating-point issue path.
//   fpu_op_e   : FP operation encoding driven to the combinational datapath
//   fpu_lat_e  : latency class used to pick the multicycle wait per operation
//   fflags_t   : RISC-V accrued exception flags {NV,DZ,OF,UF,NX}
//   DW_ST_*    : bit positions in the DesignWare status word
// Helper functions classify operations for latency, rounding-mode checking
// and flag contribution.
// ----------------------------------------------------------------------------
package ibex_fp_pkg;

    typedef enum logic [4:0] {
        FPU_NOP         = 5'd0,
        FPU_ADD         = 5'd1,
        FPU_SUB         = 5'd2,
        FPU_MUL         = 5'd3,
        FPU_DIV         = 5'd4,
        FPU_SQRT        = 5'd5,
        FPU_MADD        = 5'd6,
        FPU_MSUB        = 5'd7,
        FPU_NMADD       = 5'd8,
        FPU_NMSUB       = 5'd9,
        FPU_INT2FLOAT   = 5'd10,
        FPU_INT2FLOAT_U = 5'd11,
        FPU_FLOAT2INT   = 5'd12,
        FPU_FLOAT2INT_U = 5'd13,
        FPU_CMP         = 5'd14,
        FPU_SGNJ        = 5'd15,
        FPU_SGNJN       = 5'd16,
        FPU_SGNJX       = 5'd17,
        FPU_MOVE_F2I    = 5'd18,
        FPU_MOVE_I2F    = 5'd19,
        FPU_FCLASS      = 5'd20,
        FPU_MIN         = 5'd21,
        FPU_MAX         = 5'd22
    } fpu_op_e;

    typedef enum logic [2:0] {
        LAT_CLS_OTHER = 3'd0,
        LAT_CLS_MUL   = 3'd1,
        LAT_CLS_MAC   = 3'd2,
        LAT_CLS_DIV   = 3'd3,
        LAT_CLS_SQRT  = 3'd4
    } fpu_lat_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int DW_ST_INVALID = 2;
    localparam int DW_ST_TINY    = 3;
    localparam int DW_ST_HUGE    = 4;
    localparam int DW_ST_INEXACT = 5;

    // Instruction rm field value meaning "use the CSR frm".
    localparam logic [2:0] RM_DYN = 3'b111;

    function automatic fpu_lat_e fpu_lat_class(input fpu_op_e op);
        fpu_lat_e cls;
        case (op)
            FPU_DIV:  cls = LAT_CLS_DIV;
            FPU_SQRT: cls = LAT_CLS_SQRT;
            FPU_MADD, FPU_MSUB,
            FPU_NMADD, FPU_NMSUB: cls = LAT_CLS_MAC;
            FPU_MUL:  cls = LAT_CLS_MUL;
            default:  cls = LAT_CLS_OTHER;
        endcase
        return cls;
    endfunction

    // Operations whose result depends on rounding, so rm 5..7 is illegal.
    function automatic logic fpu_rm_checked(input fpu_op_e op);
        logic chk;
        case (op)
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT,
            FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB,
            FPU_INT2FLOAT, FPU_INT2FLOAT_U,
            FPU_FLOAT2INT, FPU_FLOAT2INT_U: chk = 1'b1;
            default: chk = 1'b0;
        endcase
        return chk;
    endfunction

    // Non-arithmetic operations can only raise invalid.
    function automatic logic fpu_nv_only(input fpu_op_e op);
        logic nv;
        case (op)
            FPU_CMP, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
            FPU_MOVE_F2I, FPU_MOVE_I2F, FPU_FCLASS,
            FPU_MIN, FPU_MAX: nv = 1'b1;
            default: nv = 1'b0;
        endcase
        return nv;
    endfunction

endpackage

// File: rtl/ibex_fpu_fflags.sv
// ----------------------------------------------------------------------------
// ibex_fpu_fflags
// Maps the DesignWare status of the executing operation onto RISC-V fflags,
// holds them pending until writeback, then ORs them into the sticky register.
//   clk, rst  : clock, asynchronous active-high reset
//   capture   : sample the flags of the current operation (last EXEC cycle)
//   commit    : writeback handshake, accumulate pending flags
//   clr       : clear the sticky flags (a same-cycle commit still lands)
//   op        : operation held on the datapath
//   rs1, rs2  : operands held on the datapath (for divide-by-zero detection)
//   status    : DesignWare status word of the selected unit
//   fflags    : sticky {NV,DZ,OF,UF,NX}
// ----------------------------------------------------------------------------
module ibex_fpu_fflags
    import ibex_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        commit,
    input  logic        clr,
    input  fpu_op_e     op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [7:0]  status,
    output logic [4:0]  fflags
);

    fflags_t new_flags;
    fflags_t pending;
    fflags_t sticky;

    logic unused_bits;
    assign unused_bits = ^{status[7:6], status[1:0], rs1[31], rs2[31]};

    // DZ is derived from operands: the DW divider does not report it, and a
    // NaN/Inf or zero dividend must not raise it.
    always_comb begin
        new_flags    = '0;
        new_flags.nv = status[DW_ST_INVALID];
        if (!fpu_nv_only(op)) begin
            new_flags.dz = (op == FPU_DIV) && (rs2[30:0] == '0) &&
                           (rs1[30:23] != 8'hFF) && (rs1[30:0] != '0);
            new_flags.of = status[DW_ST_HUGE];
            new_flags.uf = status[DW_ST_TINY] & status[DW_ST_INEXACT];
            new_flags.nx = status[DW_ST_INEXACT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (capture) begin
            pending <= new_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (clr ? fflags_t'('0) : sticky) | (commit ? pending : fflags_t'('0));
        end
    end

    assign fflags = sticky;

endmodule

// File: rtl/ibex_fpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_fpu_issue_ctrl
// Issues one FP instruction at a time to the combinational ibex_FPU datapath,
// holds its inputs stable for an op-dependent number of cycles (multicycle
// paths), captures the result and offers it on a single writeback port.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   req_*                        : request handshake and instruction fields
//   frm_i                        : CSR rounding mode, used when req_rm_i = 3'b111
//   fpu_*_o                      : registered datapath drive
//   fp_wdata_i .. status_i       : datapath results and DW status
//   wb_*                         : writeback handshake, target and data
//   fflags_o, fflags_clr_i       : sticky exception flags and their clear
//   illegal_o                    : one-cycle pulse for an illegal rounding mode
//   busy_o                       : controller not idle
// Every LAT_* parameter must be at least 1.
// ----------------------------------------------------------------------------
module ibex_fpu_issue_ctrl
    import ibex_fp_pkg::*;
#(
    parameter int unsigned LAT_DIV   = 4,
    parameter int unsigned LAT_SQRT  = 4,
    parameter int unsigned LAT_MAC   = 3,
    parameter int unsigned LAT_MUL   = 2,
    parameter int unsigned LAT_OTHER = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  fpu_op_e     req_op_i,
    input  logic [2:0]  req_rm_i,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [31:0] req_rs3_i,
    input  logic [31:0] req_rs1_int_i,
    input  logic [2:0]  frm_i,
    output fpu_op_e     fpu_op_o,
    output logic [2:0]  fpu_rm_o,
    output logic [4:0]  fpu_rd_o,
    output logic [31:0] fpu_rs1_o,
    output logic [31:0] fpu_rs2_o,
    output logic [31:0] fpu_rs3_o,
    output logic [31:0] fpu_rs1_int_o,
    input  logic [31:0] fp_wdata_i,
    input  logic [31:0] int_wdata_i,
    input  logic        fp_write_i,
    input  logic        int_write_i,
    input  logic [7:0]  status_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic        wb_is_fp_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic        illegal_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e     state;
    logic [7:0] cnt;
    logic [2:0] rm_resolved;
    logic       rm_illegal;
    logic [7:0] lat_cycles;
    logic       capture;
    logic       commit;

    // The datapath only reports through fp_write_i; int_write_i is its
    // complement for every real op, so it carries no extra information.
    logic unused_int_write;
    assign unused_int_write = int_write_i;

    assign rm_resolved = (req_rm_i == RM_DYN) ? frm_i : req_rm_i;
    assign rm_illegal  = fpu_rm_checked(req_op_i) && (rm_resolved >= 3'd5);

    always_comb begin
        lat_cycles = 8'(LAT_OTHER);
        case (fpu_lat_class(req_op_i))
            LAT_CLS_DIV:  lat_cycles = 8'(LAT_DIV);
            LAT_CLS_SQRT: lat_cycles = 8'(LAT_SQRT);
            LAT_CLS_MAC:  lat_cycles = 8'(LAT_MAC);
            LAT_CLS_MUL:  lat_cycles = 8'(LAT_MUL);
            default:      lat_cycles = 8'(LAT_OTHER);
        endcase
    end

    assign req_ready_o = (state == IDLE);
    assign wb_valid_o  = (state == WB);
    assign busy_o      = (state != IDLE);
    assign capture     = (state == EXEC) && (cnt == 8'd0);
    assign commit      = (state == WB) && wb_ready_i;

    // Datapath drive is only loaded in IDLE, which keeps it frozen from the
    // cycle after accept until the controller leaves WB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            fpu_op_o      <= FPU_NOP;
            fpu_rm_o      <= '0;
            fpu_rd_o      <= '0;
            fpu_rs1_o     <= '0;
            fpu_rs2_o     <= '0;
            fpu_rs3_o     <= '0;
            fpu_rs1_int_o <= '0;
            wb_is_fp_o    <= 1'b0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
            illegal_o     <= 1'b0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        fpu_op_o      <= req_op_i;
                        fpu_rm_o      <= rm_resolved;
                        fpu_rd_o      <= req_rd_i;
                        fpu_rs1_o     <= req_rs1_i;
                        fpu_rs2_o     <= req_rs2_i;
                        fpu_rs3_o     <= req_rs3_i;
                        fpu_rs1_int_o <= req_rs1_int_i;
                        if (rm_illegal) begin
                            illegal_o <= 1'b1;
                        end else if (req_op_i != FPU_NOP) begin
                            state <= EXEC;
                            cnt   <= lat_cycles - 8'd1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 8'd0) begin
                        wb_data_o  <= fp_write_i ? fp_wdata_i : int_wdata_i;
                        wb_is_fp_o <= fp_write_i;
                        wb_rd_o    <= fpu_rd_o;
                        state      <= WB;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ibex_fpu_fflags u_fflags (
        .clk     (clk_i),
        .rst     (rst_i),
        .capture (capture),
        .commit  (commit),
        .clr     (fflags_clr_i),
        .op      (fpu_op_o),
        .rs1     (fpu_rs1_o),
        .rs2     (fpu_rs2_o),
        .status  (status_i),
        .fflags  (fflags_o)
    );

endmodule

// File: tb/tb_ibex_fpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ibex_fpu_issue_ctrl
// Self-checking bench for ibex_fpu_issue_ctrl. The bench plays the role of the
// combinational datapath: it drives junk results on every cycle except the one
// where the controller must sample them, so a wrong latency shows up as bad
// writeback data. Expected values come from a small reference model of the
// issue rules (latency per op, rm resolution, flag mapping, sticky flags).
// ----------------------------------------------------------------------------
module tb_ibex_fpu_issue_ctrl;
    import ibex_fp_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    fpu_op_e     req_op_i;
    logic [2:0]  req_rm_i;
    logic [4:0]  req_rd_i;
    logic [31:0] req_rs1_i, req_rs2_i, req_rs3_i, req_rs1_int_i;
    logic [2:0]  frm_i;
    fpu_op_e     fpu_op_o;
    logic [2:0]  fpu_rm_o;
    logic [4:0]  fpu_rd_o;
    logic [31:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_rs1_int_o;
    logic [31:0] fp_wdata_i, int_wdata_i;
    logic        fp_write_i, int_write_i;
    logic [7:0]  status_i;
    logic        wb_valid_o, wb_ready_i, wb_is_fp_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        illegal_o;
    logic        busy_o;

    int   checks = 0;
    int   errors = 0;
    logic [4:0] exp_fflags = '0;

    ibex_fpu_issue_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_rm_i      (req_rm_i),
        .req_rd_i      (req_rd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rs3_i     (req_rs3_i),
        .req_rs1_int_i (req_rs1_int_i),
        .frm_i         (frm_i),
        .fpu_op_o      (fpu_op_o),
        .fpu_rm_o      (fpu_rm_o),
        .fpu_rd_o      (fpu_rd_o),
        .fpu_rs1_o     (fpu_rs1_o),
        .fpu_rs2_o     (fpu_rs2_o),
        .fpu_rs3_o     (fpu_rs3_o),
        .fpu_rs1_int_o (fpu_rs1_int_o),
        .fp_wdata_i    (fp_wdata_i),
        .int_wdata_i   (int_wdata_i),
        .fp_write_i    (fp_write_i),
        .int_write_i   (int_write_i),
        .status_i      (status_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_is_fp_o    (wb_is_fp_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .fflags_o      (fflags_o),
        .fflags_clr_i  (fflags_clr_i),
        .illegal_o     (illegal_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference rules, written as plain lookup tables over the op list.
    function automatic int latOf(input fpu_op_e op);
        case (op)
            FPU_DIV, FPU_SQRT:                          return 4;
            FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB:   return 3;
            FPU_MUL:                                    return 2;
            default:                                    return 1;
        endcase
    endfunction

    function automatic bit rmChecked(input fpu_op_e op);
        return op inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_MADD,
                          FPU_MSUB, FPU_NMADD, FPU_NMSUB, FPU_INT2FLOAT,
                          FPU_INT2FLOAT_U, FPU_FLOAT2INT, FPU_FLOAT2INT_U};
    endfunction

    function automatic logic [4:0] flagsOf(input fpu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [7:0] st);
        logic nv, dz, of, uf, nx;
        nv = st[2];
        of = st[4];
        uf = st[3] && st[5];
        nx = st[5];
        dz = (op == FPU_DIV) && (b[30:0] == 0) && (a[30:23] != 8'hFF) && (a[30:0] != 0);
        if (op inside {FPU_CMP, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX, FPU_MOVE_F2I,
                       FPU_MOVE_I2F, FPU_FCLASS, FPU_MIN, FPU_MAX}) begin
            return {nv, 4'b0000};
        end
        return {nv, dz, of, uf, nx};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic junkDatapath();
        fp_wdata_i  = $urandom;
        int_wdata_i = $urandom;
        fp_write_i  = 1'($urandom_range(0, 1));
        int_write_i = ~fp_write_i;
        status_i    = 8'($urandom);
    endtask

    task automatic junkRequest();
        req_valid_i   = 1'($urandom_range(0, 1));
        req_op_i      = fpu_op_e'(5'($urandom_range(1, 22)));
        req_rm_i      = 3'($urandom);
        req_rd_i      = 5'($urandom);
        req_rs1_i     = $urandom;
        req_rs2_i     = $urandom;
        req_rs3_i     = $urandom;
        req_rs1_int_i = $urandom;
        frm_i         = 3'($urandom);
    endtask

    // Issue one instruction starting at a negedge with the controller idle;
    // returns at the negedge after it has fully completed.
    task automatic applyStimulus(input fpu_op_e op, input logic [2:0] rm, input logic [2:0] frm,
                                 input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] ai, input logic fpw,
                                 input logic [31:0] fdata, input logic [31:0] idata,
                                 input logic [7:0] st, input int hold, input logic clr);
        logic [2:0]  erm;
        logic [4:0]  newf;
        logic [31:0] edata;
        int          lat;
        erm   = (rm == 3'b111) ? frm : rm;
        newf  = flagsOf(op, a, b, st);
        edata = fpw ? fdata : idata;
        lat   = latOf(op);

        req_valid_i = 1'b1; req_op_i = op; req_rm_i = rm; req_rd_i = rd;
        req_rs1_i = a; req_rs2_i = b; req_rs3_i = c; req_rs1_int_i = ai; frm_i = frm;
        checkOutput("ready_before_accept", req_ready_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        frm_i = 3'($urandom);
        checkOutput("fpu_op", fpu_op_o, op);
        checkOutput("fpu_rm", fpu_rm_o, erm);
        checkOutput("fpu_rd", fpu_rd_o, rd);
        checkOutput("fpu_rs2", fpu_rs2_o, b);
        checkOutput("fpu_rs3", fpu_rs3_o, c);
        checkOutput("fpu_rs1_int", fpu_rs1_int_o, ai);

        if (rmChecked(op) && erm >= 3'd5) begin
            checkOutput("illegal_pulse", illegal_o, 1'b1);
            checkOutput("illegal_no_busy", busy_o, 1'b0);
            checkOutput("illegal_no_wb", wb_valid_o, 1'b0);
            checkOutput("illegal_ready", req_ready_o, 1'b1);
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("illegal_one_cycle", illegal_o, 1'b0);
            checkOutput("illegal_still_no_wb", wb_valid_o, 1'b0);
            checkOutput("illegal_flags", fflags_o, exp_fflags);
            return;
        end
        checkOutput("no_illegal", illegal_o, 1'b0);
        if (op == FPU_NOP) begin
            checkOutput("nop_idle", busy_o, 1'b0);
            checkOutput("nop_no_wb", wb_valid_o, 1'b0);
            return;
        end

        for (int cyc = 1; cyc <= lat; cyc++) begin
            checkOutput("exec_busy", busy_o, 1'b1);
            checkOutput("exec_not_ready", req_ready_o, 1'b0);
            checkOutput("exec_no_wb", wb_valid_o, 1'b0);
            checkOutput("exec_rs1_stable", fpu_rs1_o, a);
            checkOutput("exec_op_stable", fpu_op_o, op);
            if (cyc == lat) begin
                fp_wdata_i = fdata; int_wdata_i = idata;
                fp_write_i = fpw; int_write_i = ~fpw; status_i = st;
            end else begin
                junkDatapath();
            end
            junkRequest();
            @(posedge clk_i);
            @(negedge clk_i);
        end

        junkDatapath();
        checkOutput("wb_valid", wb_valid_o, 1'b1);
        checkOutput("wb_data", wb_data_o, edata);
        checkOutput("wb_is_fp", wb_is_fp_o, fpw);
        checkOutput("wb_rd", wb_rd_o, rd);
        checkOutput("wb_not_ready", req_ready_o, 1'b0);
        checkOutput("flags_before_hs", fflags_o, exp_fflags);
        for (int h = 0; h < hold; h++) begin
            wb_ready_i = 1'b0;
            junkDatapath();
            junkRequest();
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("hold_wb_valid", wb_valid_o, 1'b1);
            checkOutput("hold_wb_data", wb_data_o, edata);
            checkOutput("hold_wb_is_fp", wb_is_fp_o, fpw);
            checkOutput("hold_wb_rd", wb_rd_o, rd);
            checkOutput("hold_not_ready", req_ready_o, 1'b0);
            checkOutput("hold_rs2_stable", fpu_rs2_o, b);
        end
        wb_ready_i   = 1'b1;
        fflags_clr_i = clr;
        @(posedge clk_i);
        @(negedge clk_i);
        wb_ready_i   = 1'b0;
        fflags_clr_i = 1'b0;
        req_valid_i  = 1'b0;
        exp_fflags   = (clr ? 5'b0 : exp_fflags) | newf;
        checkOutput("after_hs_no_wb", wb_valid_o, 1'b0);
        checkOutput("after_hs_idle", busy_o, 1'b0);
        checkOutput("after_hs_ready", req_ready_o, 1'b1);
        checkOutput("after_hs_flags", fflags_o, exp_fflags);
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_op_i = FPU_NOP; req_rm_i = '0; req_rd_i = '0;
        req_rs1_i = '0; req_rs2_i = '0; req_rs3_i = '0; req_rs1_int_i = '0; frm_i = '0;
        fp_wdata_i = '0; int_wdata_i = '0; fp_write_i = 1'b0; int_write_i = 1'b0;
        status_i = '0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("rst_ready", req_ready_o, 1'b1);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_wb_valid", wb_valid_o, 1'b0);
        checkOutput("rst_fflags", fflags_o, 5'b0);
        checkOutput("rst_fpu_op", fpu_op_o, FPU_NOP);
        checkOutput("rst_illegal", illegal_o, 1'b0);
        checkOutput("rst_wb_data", wb_data_o, 32'h0);

        $display("[TB] directed: ADD 1.0+2.0");
        applyStimulus(FPU_ADD, 3'd0, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 32'h0, 32'h0,
                      1'b1, 32'h40400000, 32'h0, 8'h00, 0, 1'b0);
        checkOutput("add_flags", fflags_o, 5'b00000);

        $display("[TB] directed: DIV 1.0/0.0");
        applyStimulus(FPU_DIV, 3'd0, 3'd0, 5'd4, 32'h3F800000, 32'h00000000, 32'h0, 32'h0,
                      1'b1, 32'h7F800000, 32'h0, 8'h00, 0, 1'b0);
        checkOutput("div0_flags", fflags_o, 5'b01000);

        $display("[TB] directed: FLOAT2INT rm=5");
        applyStimulus(FPU_FLOAT2INT, 3'd5, 3'd0, 5'd5, 32'h3F800000, 32'h0, 32'h0, 32'h0,
                      1'b0, 32'h0, 32'h1, 8'h00, 0, 1'b0);

        $display("[TB] directed: dynamic rm resolving to 6");
        applyStimulus(FPU_MUL, 3'b111, 3'd6, 5'd6, 32'h3F800000, 32'h40000000, 32'h0, 32'h0,
                      1'b1, 32'h40000000, 32'h0, 8'h00, 0, 1'b0);

        $display("[TB] directed: MUL with writeback stalled 6 cycles");
        applyStimulus(FPU_MUL, 3'b111, 3'd1, 5'd7, 32'h40000000, 32'h40400000, 32'h0, 32'h0,
                      1'b1, 32'h40C00000, 32'h0, 8'h00, 6, 1'b0);

        $display("[TB] directed: DIV 1.0/3.0 inexact with clear at handshake");
        applyStimulus(FPU_DIV, 3'd0, 3'd0, 5'd8, 32'h3F800000, 32'h40400000, 32'h0, 32'h0,
                      1'b1, 32'h3EAAAAAB, 32'h0, 8'h20, 0, 1'b1);
        checkOutput("clr_and_set", fflags_o, 5'b00001);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 40; n++) begin
            fpu_op_e     op;
            logic [31:0] b;
            op = fpu_op_e'(5'($urandom_range(0, 22)));
            b  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            applyStimulus(op, ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom),
                          3'($urandom), 5'($urandom), $urandom, b, $urandom, $urandom,
                          1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom),
                          $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] standalone flag clear");
        fflags_clr_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        fflags_clr_i = 1'b0;
        exp_fflags = 5'b0;
        checkOutput("idle_clear", fflags_o, exp_fflags);
        applyStimulus(FPU_FCLASS, 3'd7, 3'd7, 5'd9, 32'h7F800001, 32'h0, 32'h0, 32'h0,
                      1'b0, 32'h0, 32'h100, 8'h3C, 0, 1'b0);
        checkOutput("nv_only_flags", fflags_o, 5'b10000);

        $display("[TB] reset during SQRT execution");
        req_valid_i = 1'b1; req_op_i = FPU_SQRT; req_rm_i = 3'd0; req_rd_i = 5'd10;
        req_rs1_i = 32'h40800000; req_rs2_i = 32'h0; req_rs3_i = 32'h0; req_rs1_int_i = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("sqrt_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        exp_fflags = 5'b0;
        checkOutput("mid_rst_busy", busy_o, 1'b0);
        checkOutput("mid_rst_wb_valid", wb_valid_o, 1'b0);
        checkOutput("mid_rst_fpu_op", fpu_op_o, FPU_NOP);
        checkOutput("mid_rst_fpu_rs1", fpu_rs1_o, 32'h0);
        checkOutput("mid_rst_fflags", fflags_o, exp_fflags);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("post_rst_no_wb", wb_valid_o, 1'b0);
        end
        applyStimulus(FPU_ADD, 3'd0, 3'd0, 5'd11, 32'h3F800000, 32'h40000000, 32'h0, 32'h0,
                      1'b1, 32'h40400000, 32'h0, 8'h00, 0, 1'b0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
